// File: rtl/data_select_pipe_pkg.sv
// Shared opcodes and width helpers for the select/add/sub/accumulate pipe.
// Helpers work on 64-bit containers so any AW up to 64 can use them.
package data_select_pipe_pkg;

   localparam logic [2:0] OP_PASS_A  = 3'd0;
   localparam logic [2:0] OP_PASS_B  = 3'd1;
   localparam logic [2:0] OP_ADD     = 3'd2;
   localparam logic [2:0] OP_SUB     = 3'd3;
   localparam logic [2:0] OP_NEG_A   = 3'd4;
   localparam logic [2:0] OP_ACC_ADD = 3'd5;
   localparam logic [2:0] OP_ACC_CLR = 3'd6;
   localparam logic [2:0] OP_RSVD    = 3'd7;

   localparam int unsigned MAX_W = 64;

   // Sign-extend the low w bits of v to the full 64-bit container.
   function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
      logic [63:0] t;
      t = v << (MAX_W - w);
      return $signed(t) >>> (MAX_W - w);
   endfunction

   function automatic logic [63:0] sat_max(input int unsigned w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] sat_min(input int unsigned w);
      return ~sat_max(w);
   endfunction

endpackage

// File: rtl/data_select_pipe_if.sv
// Operand/result handshake bundle for data_select_pipe.
interface data_select_pipe_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 16
) ();
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic [2:0]    op;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] c;
   logic          ovf;

   modport slave  (input  in_valid, a, b, op, out_ready,
                   output in_ready, out_valid, c, ovf);
   modport master (output in_valid, a, b, op, out_ready,
                   input  in_ready, out_valid, c, ovf);
endinterface

// File: rtl/data_select_pipe_acc_sat_add.sv
// Combinational AW-bit signed add with overflow detect and optional clamping.
module acc_sat_add
   import data_select_pipe_pkg::*;
#(
   parameter int unsigned AW  = 16,
   parameter bit          SAT = 1'b1
) (
   input  logic [AW-1:0] a_i,
   input  logic [AW-1:0] b_i,
   output logic [AW-1:0] sum_o,
   output logic          ovf_o
);
   logic [AW:0] wide;

   always_comb begin
      wide  = {a_i[AW-1], a_i} + {b_i[AW-1], b_i};
      ovf_o = wide[AW] ^ wide[AW-1];
      sum_o = wide[AW-1:0];
      // The true sign sits in wide[AW]; it picks which rail to clamp to.
      if (SAT && ovf_o)
         sum_o = wide[AW] ? AW'(sat_min(AW)) : AW'(sat_max(AW));
   end
endmodule

// File: rtl/data_select_pipe.sv
// Two-stage pipelined signed select/add/sub/negate/accumulate unit with
// valid/ready handshake on both sides and a sticky accumulator overflow flag.
module data_select_pipe
   import data_select_pipe_pkg::*;
#(
   parameter int unsigned DW  = 8,
   parameter int unsigned AW  = 16,
   parameter bit          SAT = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   data_select_pipe_if.slave dp
);
   if (AW < DW + 2 || AW > MAX_W) begin : g_bad_width
      $error("data_select_pipe: AW must satisfy DW+2 <= AW <= 64");
   end

   logic          s1_valid_q, s1_valid_d;
   logic [DW-1:0] s1_a_q, s1_a_d;
   logic [DW-1:0] s1_b_q, s1_b_d;
   logic [2:0]    s1_op_q, s1_op_d;
   logic          out_valid_q, out_valid_d;
   logic [AW-1:0] c_q, c_d;
   logic [AW-1:0] acc_q, acc_d;
   logic          ovf_q, ovf_d;

   logic          adv1, adv2;
   logic [DW:0]   ea, eb, narrow;
   logic [AW-1:0] a_ext, acc_sum;
   logic          acc_ovf;

   assign ea    = {s1_a_q[DW-1], s1_a_q};
   assign eb    = {s1_b_q[DW-1], s1_b_q};
   assign a_ext = AW'(sext(64'(s1_a_q), DW));

   acc_sat_add #(.AW(AW), .SAT(SAT)) u_acc (
      .a_i   (acc_q),
      .b_i   (a_ext),
      .sum_o (acc_sum),
      .ovf_o (acc_ovf)
   );

   always_comb begin
      adv2 = !out_valid_q || dp.out_ready;
      adv1 = !s1_valid_q || adv2;

      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      if (adv1) begin
         s1_valid_d = dp.in_valid;
         if (dp.in_valid) begin
            s1_a_d  = dp.a;
            s1_b_d  = dp.b;
            s1_op_d = dp.op;
         end
      end

      // DW+1 bits hold every ops 0-4 result, including -(-2^(DW-1)).
      case (s1_op_q)
         OP_PASS_A: narrow = ea;
         OP_PASS_B: narrow = eb;
         OP_ADD:    narrow = ea + eb;
         OP_SUB:    narrow = ea - eb;
         OP_NEG_A:  narrow = -ea;
         default:   narrow = '0;
      endcase

      out_valid_d = out_valid_q;
      c_d         = c_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      if (adv2) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            case (s1_op_q)
               OP_ACC_ADD: begin
                  acc_d = acc_sum;
                  ovf_d = ovf_q | acc_ovf;
                  c_d   = acc_sum;
               end
               OP_ACC_CLR: begin
                  acc_d = '0;
                  ovf_d = 1'b0;
                  c_d   = '0;
               end
               OP_RSVD: c_d = '0;
               default: c_d = AW'(sext(64'(narrow), DW + 1));
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= '0;
         out_valid_q <= 1'b0;
         c_q         <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         out_valid_q <= out_valid_d;
         c_q         <= c_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
      end
   end

   assign dp.in_ready  = adv1;
   assign dp.out_valid = out_valid_q;
   assign dp.c         = c_q;
   assign dp.ovf       = ovf_q;
endmodule

// File: tb/tb_data_select_pipe.sv
// Scoreboard bench: one saturating and one wrapping instance driven identically,
// each checked against a behavioural model of the opcode table.
module tb_data_select_pipe;
   import data_select_pipe_pkg::*;

   localparam int ACC_MAX = 32767;
   localparam int ACC_MIN = -32768;

   typedef struct {
      int c;
      int ovf;
      int cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   ncyc;
   bit   lat_chk;
   int   m_acc [2];
   int   m_ovf [2];
   exp_t q1 [$];
   exp_t q0 [$];

   data_select_pipe_if #(.DW(8), .AW(16)) if1 ();
   data_select_pipe_if #(.DW(8), .AW(16)) if0 ();

   data_select_pipe #(.DW(8), .AW(16), .SAT(1'b1)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .dp    (if1)
   );

   data_select_pipe #(.DW(8), .AW(16), .SAT(1'b0)) dut_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .dp    (if0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, ncyc);
      end
   endtask

   function automatic exp_t model(input int s, input int op, input int a, input int b, input int cyc);
      exp_t e;
      int   t;
      e.cyc = cyc;
      e.c   = 0;
      case (op)
         0: e.c = a;
         1: e.c = b;
         2: e.c = a + b;
         3: e.c = a - b;
         4: e.c = -a;
         5: begin
            t = m_acc[s] + a;
            if (t > ACC_MAX || t < ACC_MIN) begin
               m_ovf[s] = 1;
               if (s == 1) t = (t > ACC_MAX) ? ACC_MAX : ACC_MIN;
               else        t = (t > ACC_MAX) ? t - 65536 : t + 65536;
            end
            m_acc[s] = t;
            e.c = t;
         end
         6: begin
            m_acc[s] = 0;
            m_ovf[s] = 0;
         end
         default: e.c = 0;
      endcase
      e.ovf = m_ovf[s];
      return e;
   endfunction

   task automatic drive(input bit v, input logic [2:0] op, input int a, input int b, input bit ordy);
      if1.in_valid = v;  if0.in_valid = v;
      if1.op = op;       if0.op = op;
      if1.a = a[7:0];    if0.a = a[7:0];
      if1.b = b[7:0];    if0.b = b[7:0];
      if1.out_ready = ordy;
      if0.out_ready = ordy;
   endtask

   // Called just after a falling edge with inputs set; returns at the next falling edge.
   task automatic cyc(output bit fired);
      exp_t e;
      #1;
      fired = if1.in_valid && if1.in_ready;
      if (if1.out_valid && if1.out_ready) begin
         if (q1.size() == 0) check("sat_spurious_out", 1, 0);
         else begin
            e = q1.pop_front();
            check("sat_c", int'($signed(if1.c)), e.c);
            check("sat_ovf", int'(if1.ovf), e.ovf);
            if (lat_chk) check("sat_latency", ncyc - e.cyc, 2);
         end
      end
      if (if0.out_valid && if0.out_ready) begin
         if (q0.size() == 0) check("wrap_spurious_out", 1, 0);
         else begin
            e = q0.pop_front();
            check("wrap_c", int'($signed(if0.c)), e.c);
            check("wrap_ovf", int'(if0.ovf), e.ovf);
            if (lat_chk) check("wrap_latency", ncyc - e.cyc, 2);
         end
      end
      if (if1.in_valid && if1.in_ready)
         q1.push_back(model(1, int'(if1.op), int'($signed(if1.a)), int'($signed(if1.b)), ncyc));
      if (if0.in_valid && if0.in_ready)
         q0.push_back(model(0, int'(if0.op), int'($signed(if0.a)), int'($signed(if0.b)), ncyc));
      @(negedge clk);
      ncyc++;
   endtask

   task automatic beat(input logic [2:0] op, input int a, input int b);
      bit f;
      bit done;
      done = 1'b0;
      drive(1'b1, op, a, b, 1'b1);
      for (int k = 0; k < 50 && !done; k++) begin
         cyc(f);
         if (f) done = 1'b1;
      end
      if (!done) check("beat_accept_timeout", 0, 1);
   endtask

   task automatic drain();
      bit f;
      drive(1'b0, OP_PASS_A, 0, 0, 1'b1);
      for (int k = 0; k < 100 && (q1.size() + q0.size()) != 0; k++) cyc(f);
      check("drain_empty", q1.size() + q0.size(), 0);
   endtask

   initial begin
      bit f;
      int accepted;
      int c_hold;
      n_checks = 0;
      n_fail   = 0;
      ncyc     = 0;
      lat_chk  = 1'b0;
      m_acc    = '{0, 0};
      m_ovf    = '{0, 0};
      rst_n    = 1'b0;
      drive(1'b0, OP_PASS_A, 0, 0, 1'b1);

      @(negedge clk);
      #1;
      check("rst_out_valid", int'(if1.out_valid), 0);
      check("rst_c", int'(if1.c), 0);
      check("rst_ovf", int'(if1.ovf), 0);
      check("rst_in_ready", int'(if1.in_ready), 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Ops 0-4 at the operand extremes, then a short accumulator chain.
      lat_chk = 1'b1;
      for (int op = 0; op < 5; op++) beat(3'(op), -128, 127);
      beat(OP_ACC_CLR, 0, 0);
      for (int i = 0; i < 3; i++) beat(OP_ACC_ADD, 100, 0);
      drain();

      // Walk the accumulator to 32700, overflow it, step back, then clear.
      beat(OP_ACC_CLR, 0, 0);
      for (int i = 0; i < 257; i++) beat(OP_ACC_ADD, 127, 0);
      beat(OP_ACC_ADD, 61, 0);
      beat(OP_ACC_ADD, 127, 0);
      beat(OP_ACC_ADD, -1, 0);
      beat(OP_ACC_CLR, 0, 0);
      drain();
      lat_chk = 1'b0;

      // Backpressure: three ACC_ADD beats offered against a 5-cycle stall.
      accepted = 0;
      c_hold   = 0;
      drive(1'b1, OP_ACC_ADD, 10, 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         if (i >= 2) begin
            check("stall_in_ready", int'(if1.in_ready), 0);
            check("stall_out_valid", int'(if1.out_valid), 1);
            if (i == 2) c_hold = int'($signed(if1.c));
            else check("stall_c_hold", int'($signed(if1.c)), c_hold);
         end
         cyc(f);
         if (f) begin
            accepted++;
            drive(1'b1, OP_ACC_ADD, 10 * (accepted + 1), 0, 1'b0);
         end
      end
      check("stall_accepted", accepted, 2);
      drive(1'b1, OP_ACC_ADD, 30, 0, 1'b1);
      for (int k = 0; k < 20 && accepted < 3; k++) begin
         cyc(f);
         if (f) begin
            accepted++;
            drive(1'b0, OP_PASS_A, 0, 0, 1'b1);
         end
      end
      check("release_accepted", accepted, 3);
      drain();

      // Force ovf high, fill both stages, then reset mid-flight.
      beat(OP_ACC_CLR, 0, 0);
      for (int i = 0; i < 259; i++) beat(OP_ACC_ADD, 127, 0);
      drain();
      check("pre_rst_ovf", int'(if1.ovf), 1);
      drive(1'b1, OP_ACC_ADD, 1, 0, 1'b0);
      cyc(f);
      cyc(f);
      rst_n = 1'b0;
      drive(1'b0, OP_PASS_A, 0, 0, 1'b1);
      #1;
      check("midrst_out_valid", int'(if1.out_valid), 0);
      check("midrst_c", int'(if1.c), 0);
      check("midrst_ovf_sat", int'(if1.ovf), 0);
      check("midrst_ovf_wrap", int'(if0.ovf), 0);
      check("midrst_in_ready", int'(if1.in_ready), 1);
      q1.delete();
      q0.delete();
      m_acc = '{0, 0};
      m_ovf = '{0, 0};
      cyc(f);
      rst_n = 1'b1;
      beat(OP_ACC_ADD, 5, 0);
      drain();

      // Random traffic with random backpressure.
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               $urandom_range(0, 3) != 0);
         cyc(f);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
